// File: rtl/npu_pkg.sv
// npu_pkg: register map, status bit positions, FSM state type and helpers
// shared by the Wishbone systolic NPU and its processing elements.
package npu_pkg;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_W      = 12'h400;
    localparam logic [11:0] OFF_IN     = 12'h800;
    localparam logic [11:0] OFF_OUT    = 12'hC00;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_FULL     = 3;
    localparam int ST_ROWS_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } npu_state_e;

    // Ceiling log2, never below 1 so it can always size a vector.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/npu_pe.sv
// npu_pe: one weight-stationary MAC cell; activations flow right, partial
// sums flow down, both through one register stage.
module npu_pe
    import npu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int ACCW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic signed [ACCW-1:0] up,
    input  logic signed [DW-1:0]   left,
    input  logic signed [DW-1:0]   w,
    output logic signed [DW-1:0]   right,
    output logic signed [ACCW-1:0] down
);

    logic signed [DW-1:0]   right_q, right_d;
    logic signed [ACCW-1:0] down_q, down_d;
    logic signed [2*DW-1:0] prod;

    // The full-width product is exact; resizing to ACCW keeps it modulo 2^ACCW.
    always_comb begin
        prod    = left * w;
        right_d = left;
        down_d  = up + ACCW'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            right_q <= '0;
            down_q  <= '0;
        end else if (en) begin
            right_q <= right_d;
            down_q  <= down_d;
        end
    end

    assign right = right_q;
    assign down  = down_q;

endmodule

// File: rtl/npu_wb_array.sv
// npu_wb_array: Wishbone-attached N x N weight-stationary systolic array
// computing Y = X * W over a batch of up to DEPTH buffered input rows.
module npu_wb_array
    import npu_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR = 20'h30000,
    parameter int          N         = 3,
    parameter int          DW        = 8,
    parameter int          ACCW      = 16,
    parameter int          DEPTH     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        busy_o,
    output logic        irq_o
);

    localparam int          RW  = clog2(DEPTH + 1);
    localparam int          XIW = clog2(DEPTH);
    localparam int          WIW = clog2(N * N);
    localparam int          YIW = clog2(DEPTH * N);
    localparam int          CW  = clog2(2 * N);
    localparam int          TL  = 2 * N - 1;
    localparam int unsigned NW  = N * N;
    localparam int unsigned NY  = DEPTH * N;

    npu_state_e     state_q, state_d;
    logic [RW-1:0]  rows_q, rows_d, ptr_q, ptr_d;
    logic [CW-1:0]  dcnt_q, dcnt_d;
    logic           done_q, done_d, ovf_q, ovf_d, busy_q, busy_d, ack_q, ack_d;
    logic [31:0]    dat_q, dat_d;
    logic [TL-1:0]  tag_vld_q, tag_vld_d;
    logic [XIW-1:0] tag_k_q [TL];
    logic [XIW-1:0] tag_k_d [TL];

    logic signed [DW-1:0]   w_mem [N*N];
    logic [N*DW-1:0]        x_mem [DEPTH];
    logic signed [ACCW-1:0] y_mem [DEPTH*N];

    logic [11:0]            off;
    logic [7:0]             aidx;
    logic                   hit, req, wr, rd, idle, in_full, pop, ctrl_wr;
    logic                   is_ctrl, is_stat, is_w, is_in, is_out, w_we, x_we;
    logic [31:0]            status;
    logic [N*DW-1:0]        x_row;
    logic signed [DW-1:0]   lane_in [N];
    logic signed [DW-1:0]   h [N][N];
    logic signed [ACCW-1:0] v [N+1][N];
    logic signed [ACCW-1:0] col_out [N];
    logic signed [DW-1:0]   unused_right [N];
    logic                   unused_ok;

    assign off     = wb_adr_i[11:0];
    assign aidx    = off[9:2];
    assign hit     = (wb_adr_i[31:12] == BASE_ADDR);
    assign req     = hit & wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr      = req & wb_we_i;
    assign rd      = req & ~wb_we_i;
    assign idle    = (state_q == IDLE);
    assign in_full = (rows_q == RW'(DEPTH));
    assign is_ctrl = (off[11:2] == OFF_CTRL[11:2]);
    assign is_stat = (off[11:2] == OFF_STATUS[11:2]);
    assign is_in   = (off[11:2] == OFF_IN[11:2]);
    assign is_w    = (off[11:10] == OFF_W[11:10]) && (32'(aidx) < NW);
    assign is_out  = (off[11:10] == OFF_OUT[11:10]) && (32'(aidx) < NY);
    // Configuration writes only land while the array is idle; reads always do.
    assign ctrl_wr = wr & idle & is_ctrl;
    assign w_we    = wr & idle & is_w;
    assign x_we    = wr & idle & is_in & ~in_full;
    assign x_row   = x_mem[ptr_q[XIW-1:0]];

    always_comb begin
        status                      = '0;
        status[ST_BUSY]             = busy_q;
        status[ST_DONE]             = done_q;
        status[ST_OVF]              = ovf_q;
        status[ST_FULL]             = in_full;
        status[ST_ROWS_LSB +: 8]    = 8'(rows_q);
    end

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        pop     = 1'b0;
        if (wr && idle && is_in) begin
            if (in_full) ovf_d  = 1'b1;
            else         rows_d = rows_q + RW'(1);
        end
        case (state_q)
            IDLE: begin
                // CLEAR wins over START when both bits are written together.
                if (ctrl_wr && wb_dat_i[CTRL_CLEAR]) begin
                    rows_d = '0;
                    done_d = 1'b0;
                    ovf_d  = 1'b0;
                end else if (ctrl_wr && wb_dat_i[CTRL_START]) begin
                    if (rows_q != '0) begin
                        state_d = RUN;
                        done_d  = 1'b0;
                        ptr_d   = '0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                pop = 1'b1;
                if (ptr_q == rows_q - RW'(1)) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    ptr_d = ptr_q + RW'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == CW'(2 * N - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);

        ack_d = req;
        dat_d = '0;
        if (rd) begin
            if (is_stat)     dat_d = status;
            else if (is_w)   dat_d = 32'(w_mem[aidx[WIW-1:0]]);
            else if (is_out) dat_d = 32'(y_mem[aidx[YIW-1:0]]);
        end

        // Row index travels alongside the data so the write-back knows its k.
        tag_vld_d[0] = pop;
        tag_k_d[0]   = ptr_q[XIW-1:0];
        for (int t = 1; t < TL; t++) begin
            tag_vld_d[t] = tag_vld_q[t-1];
            tag_k_d[t]   = tag_k_q[t-1];
        end

        for (int i = 0; i < N; i++) begin
            lane_in[i] = pop ? x_row[i*DW +: DW] : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            ptr_q     <= '0;
            dcnt_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            tag_vld_q <= '0;
            tag_k_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            if (busy_q) begin
                tag_vld_q <= tag_vld_d;
                tag_k_q   <= tag_k_d;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_we) w_mem[aidx[WIW-1:0]] <= wb_dat_i[DW-1:0];
        if (x_we) x_mem[rows_q[XIW-1:0]] <= wb_dat_i[N*DW-1:0];
        if (tag_vld_q[TL-1]) begin
            for (int j = 0; j < N; j++) begin
                y_mem[YIW'(int'(tag_k_q[TL-1]) * N + j)] <= col_out[j];
            end
        end
    end

    // Input skew: lane i waits i cycles so row k meets PE(i,0) diagonally.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_pass
            assign h[0][0] = lane_in[0];
        end else begin : g_dly
            logic signed [DW-1:0] sr_q [gi];
            logic signed [DW-1:0] sr_d [gi];
            always_comb begin
                sr_d[0] = lane_in[gi];
                for (int s = 1; s < gi; s++) sr_d[s] = sr_q[s-1];
            end
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni)  sr_q <= '{default: '0};
                else if (busy_q) sr_q <= sr_d;
            end
            assign h[gi][0] = sr_q[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DW-1:0] r_out;
            if (gi == 0) begin : g_top
                assign v[0][gj] = '0;
            end
            npu_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
                .clk   (wb_clk_i),
                .rst_n (wb_rst_ni),
                .en    (busy_q),
                .up    (v[gi][gj]),
                .left  (h[gi][gj]),
                .w     (w_mem[gi*N+gj]),
                .right (r_out),
                .down  (v[gi+1][gj])
            );
            if (gj < N - 1) begin : g_fwd
                assign h[gi][gj+1] = r_out;
            end else begin : g_end
                assign unused_right[gi] = r_out;
            end
        end
    end

    // Output deskew: column j waits N-1-j cycles so a whole row lands at once.
    for (genvar gj = 0; gj < N; gj++) begin : g_dsk
        if (gj == N - 1) begin : g_pass
            assign col_out[gj] = v[N][gj];
        end else begin : g_dly
            localparam int D = N - 1 - gj;
            logic signed [ACCW-1:0] sr_q [D];
            logic signed [ACCW-1:0] sr_d [D];
            always_comb begin
                sr_d[0] = v[N][gj];
                for (int s = 1; s < D; s++) sr_d[s] = sr_q[s-1];
            end
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni)  sr_q <= '{default: '0};
                else if (busy_q) sr_q <= sr_d;
            end
            assign col_out[gj] = sr_q[D-1];
        end
    end

    assign unused_ok = &{1'b0, wb_sel_i, off[1:0], wb_dat_i};

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign busy_o   = busy_q;
    assign irq_o    = done_q;

endmodule

// File: tb/tb_npu_wb_array.sv
// tb_npu_wb_array: directed and randomized bus-level test of npu_wb_array
// against a matrix-product reference model kept in the bench.
module tb_npu_wb_array;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int ACCW  = 16;
    localparam int DEPTH = 16;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h000;
    localparam logic [31:0] A_STAT = BASE + 32'h004;
    localparam logic [31:0] A_W    = BASE + 32'h400;
    localparam logic [31:0] A_IN   = BASE + 32'h800;
    localparam logic [31:0] A_OUT  = BASE + 32'hC00;

    typedef int row_t [N];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'hF;
    logic [31:0] wb_dat = '0, wb_adr = '0;
    logic        wb_ack, busy, irq;
    logic [31:0] wb_rdat;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   wm [N][N];
    row_t xq [$];
    int   ym [DEPTH][N];
    logic done_m = 1'b0;
    logic ovf_m  = 1'b0;

    npu_wb_array #(.BASE_ADDR(20'h30000), .N(N), .DW(DW), .ACCW(ACCW), .DEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb_stb_i  (wb_stb),
        .wb_cyc_i  (wb_cyc),
        .wb_we_i   (wb_we),
        .wb_sel_i  (wb_sel),
        .wb_dat_i  (wb_dat),
        .wb_adr_i  (wb_adr),
        .wb_ack_o  (wb_ack),
        .wb_dat_o  (wb_rdat),
        .busy_o    (busy),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sext_dw(input int raw);
        int m;
        m = raw & ((1 << DW) - 1);
        if (m >= (1 << (DW - 1))) m -= (1 << DW);
        return m;
    endfunction

    function automatic int wrap_acc(input longint s);
        longint m, r;
        m = longint'(1) << ACCW;
        r = s % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[15:8]  = 8'(xq.size());
        s[3]     = (xq.size() == DEPTH);
        s[2]     = ovf_m;
        s[1]     = done_m;
        return s;
    endfunction

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic acked);
        int n;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = wdat;
        acked = 1'b0; rdat = '0; n = 0;
        while (!acked && n < 4) begin
            @(posedge clk); #1; n++;
            if (wb_ack === 1'b1) begin
                acked = 1'b1;
                rdat  = wb_rdat;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] r;
        logic        a;
        wb_xfer(1'b1, adr, d, r, a);
        check("write_ack", 32'(a), 32'd1);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        logic a;
        wb_xfer(1'b0, adr, '0, d, a);
        check("read_ack", 32'(a), 32'd1);
    endtask

    task automatic set_w(input int i, input int j, input int raw);
        wr(A_W + 32'(4 * (i * N + j)), 32'(raw));
        wm[i][j] = sext_dw(raw);
    endtask

    task automatic push(input row_t r);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = r[i][DW-1:0];
        wr(A_IN, p);
        if (xq.size() < DEPTH) xq.push_back(r);
        else                   ovf_m = 1'b1;
    endtask

    task automatic clear_batch();
        wr(A_CTRL, 32'h2);
        xq.delete();
        done_m = 1'b0;
        ovf_m  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        rd(A_STAT, d);
        check(tag, d, exp_status());
    endtask

    task automatic start_batch();
        wr(A_CTRL, 32'h1);
        check("busy_after_start", 32'(busy), 32'd1);
        check("irq_after_start", 32'(irq), 32'd0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (irq !== 1'b1 && cyc < 4 * DEPTH + 4 * N + 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("irq_done", 32'(irq), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        for (int k = 0; k < xq.size(); k++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                s = 0;
                for (int i = 0; i < N; i++) s += longint'(xq[k][i]) * longint'(wm[i][j]);
                ym[k][j] = wrap_acc(s);
            end
        end
        done_m = 1'b1;
    endtask

    task automatic run_batch();
        int c;
        int nrows;
        nrows = xq.size();
        start_batch();
        wait_done(c);
        check("done_latency", 32'(c), 32'(nrows + 2 * N));
    endtask

    task automatic check_results();
        logic [31:0] d;
        for (int k = 0; k < xq.size(); k++) begin
            for (int j = 0; j < N; j++) begin
                rd(A_OUT + 32'(4 * (k * N + j)), d);
                check($sformatf("y[%0d][%0d]", k, j), d, 32'(ym[k][j]));
            end
        end
    endtask

    initial begin
        row_t        r;
        logic [31:0] d;
        logic        a;
        int          c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_dat", wb_rdat, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_status("status_after_reset");

        // Identity weights, two rows
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) set_w(i, j, (i == j) ? 1 : 0);
        for (int i = 0; i < N; i++) r[i] = i + 1;
        push(r);
        for (int i = 0; i < N; i++) r[i] = (i % 2 == 0) ? -(i + 4) : (i + 4);
        push(r);
        run_batch();
        check_results();
        check_status("status_identity");

        // General weights w[i][j] = 3i+j+1 with rows of ones and [2,0,..,-1]
        clear_batch();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) set_w(i, j, N * i + j + 1);
        for (int i = 0; i < N; i++) r[i] = 1;
        push(r);
        for (int i = 0; i < N; i++) r[i] = 0;
        r[0] = 2; r[N-1] = -1;
        push(r);
        run_batch();
        check_results();
        rd(A_W + 32'(4 * (N + 1)), d);
        check("weight_readback", d, 32'(wm[1][1]));

        // Overflow: DEPTH+1 pushes, then CLEAR
        clear_batch();
        for (int k = 0; k <= DEPTH; k++) begin
            for (int i = 0; i < N; i++) r[i] = sext_dw(int'($urandom_range(0, (1 << DW) - 1)));
            push(r);
        end
        check_status("status_overflow");
        clear_batch();
        check_status("status_cleared");

        // Write lockout while busy
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) r[i] = int'($urandom_range(0, 20)) - 10;
            push(r);
        end
        start_batch();
        wr(A_W, 32'd9);
        wait_done(c);
        rd(A_W, d);
        check("weight_locked", d, 32'(wm[0][0]));
        check_results();

        // Accumulator wrap-around with saturating-magnitude operands
        clear_batch();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) set_w(i, j, 127);
        for (int i = 0; i < N; i++) r[i] = 127;
        push(r);
        run_batch();
        check_results();

        // Zero-row START sets done at once without going busy
        clear_batch();
        wr(A_CTRL, 32'h1);
        done_m = 1'b1;
        check("zero_row_irq", 32'(irq), 32'd1);
        check("zero_row_busy", 32'(busy), 32'd0);
        check_status("status_zero_row");

        // Randomized batches
        for (int b = 0; b < 3; b++) begin
            int nrows;
            clear_batch();
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) set_w(i, j, int'($urandom_range(0, (1 << DW) - 1)));
            nrows = int'($urandom_range(1, DEPTH));
            for (int k = 0; k < nrows; k++) begin
                for (int i = 0; i < N; i++) r[i] = sext_dw(int'($urandom_range(0, (1 << DW) - 1)));
                push(r);
            end
            run_batch();
            check_results();
            check_status("status_random");
        end

        // Non-hit addresses are never acknowledged
        wb_xfer(1'b0, 32'h3000_1004, '0, d, a);
        check("nonhit_page_up", 32'(a), 32'd0);
        wb_xfer(1'b1, 32'h2000_0000, 32'h1, d, a);
        check("nonhit_page_low", 32'(a), 32'd0);
        check("nonhit_no_start", 32'(busy), 32'd0);

        // Held STATUS request: ack every other cycle, data valid with ack
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_STAT;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            check($sformatf("held_ack%0d", n), 32'(wb_ack), (n % 2 == 0) ? 32'd1 : 32'd0);
            if (n % 2 == 0) check($sformatf("held_dat%0d", n), wb_rdat, exp_status());
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;

        // Asynchronous reset in the middle of a batch
        clear_batch();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) r[i] = k + i;
            push(r);
        end
        start_batch();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ack", 32'(wb_ack), 32'd0);
        check("midrun_rst_dat", wb_rdat, 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xq.delete();
        done_m = 1'b0;
        ovf_m  = 1'b0;
        check_status("status_after_midrun_reset");
        rd(A_W + 32'(4 * (N * N - 1)), d);
        check("weight_survives_reset", d, 32'(wm[N-1][N-1]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
